// File: rtl/sensor_riego.sv
// Irrigation decision controller: periodically collects four soil-humidity samples,
// averages them and requests one pump cycle when the soil is dry, then locks out.
module sensor_riego #(
    parameter int unsigned     MUESTREO_CICLOS = 50_000_000,
    parameter int unsigned     TIMEOUT_CICLOS  = 1_000,
    parameter longint unsigned ESPERA_CICLOS   = 64'd50_000_000 * 64'd300,
    parameter logic [7:0]      UMBRAL          = 8'd51
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MODsensor,
    input  logic [3:0] maceta,
    input  logic [7:0] humedad,
    input  logic       humedad_valid,
    output logic       muestra_req,
    output logic       regar,
    output logic [7:0] humedad_prom,
    output logic       error_sensor
);

    localparam int MUE_W = (MUESTREO_CICLOS > 32'd1) ? $clog2(MUESTREO_CICLOS) : 1;
    localparam int TMO_W = (TIMEOUT_CICLOS > 32'd1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int ESP_W = (ESPERA_CICLOS > 64'd1) ? $clog2(ESPERA_CICLOS) : 1;

    localparam logic [MUE_W-1:0] MUE_FIN = MUE_W'(MUESTREO_CICLOS - 32'd1);
    localparam logic [TMO_W-1:0] TMO_FIN = TMO_W'(TIMEOUT_CICLOS - 32'd1);
    localparam logic [ESP_W-1:0] ESP_FIN = ESP_W'(ESPERA_CICLOS - 64'd1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEDIR   = 3'd1,
        ESPERAR = 3'd2,
        EVALUAR = 3'd3,
        BLOQUEO = 3'd4
    } estado_t;

    estado_t          estado_r;
    estado_t          estado_next_s;
    logic [MUE_W-1:0] strobe_cnt_r;
    logic [TMO_W-1:0] timeout_cnt_r;
    logic [ESP_W-1:0] espera_cnt_r;
    logic [9:0]       acc_r;
    logic [1:0]       num_r;
    logic             muestra_req_r;
    logic             regar_r;
    logic [7:0]       humedad_prom_r;
    logic             error_sensor_r;

    logic             acepta_s;
    logic             timeout_s;
    logic             riega_s;
    logic [7:0]       prom_s;
    logic             seco_s;
    logic             maceta_ok_s;

    assign prom_s       = acc_r[9:2];
    assign seco_s       = (prom_s < UMBRAL);
    assign maceta_ok_s  = (maceta >= 4'd1) && (maceta <= 4'd3);

    assign muestra_req  = muestra_req_r;
    assign regar        = regar_r;
    assign humedad_prom = humedad_prom_r;
    assign error_sensor = error_sensor_r;

    // Next-state decode; a disconnected sensor forces IDLE from any state.
    always_comb begin
        estado_next_s = estado_r;
        acepta_s      = 1'b0;
        timeout_s     = 1'b0;
        riega_s       = 1'b0;
        if (!MODsensor) begin
            estado_next_s = IDLE;
        end else begin
            case (estado_r)
                IDLE: begin
                    if (strobe_cnt_r == MUE_FIN) begin
                        estado_next_s = PEDIR;
                    end else begin
                        estado_next_s = IDLE;
                    end
                end
                PEDIR: begin
                    estado_next_s = ESPERAR;
                end
                ESPERAR: begin
                    if (humedad_valid) begin
                        acepta_s = 1'b1;
                        if (num_r == 2'd3) begin
                            estado_next_s = EVALUAR;
                        end else begin
                            estado_next_s = PEDIR;
                        end
                    end else if (timeout_cnt_r == TMO_FIN) begin
                        // the ADC had TIMEOUT_CICLOS cycles to answer and did not
                        timeout_s     = 1'b1;
                        estado_next_s = IDLE;
                    end else begin
                        estado_next_s = ESPERAR;
                    end
                end
                EVALUAR: begin
                    if (seco_s && maceta_ok_s) begin
                        riega_s       = 1'b1;
                        estado_next_s = BLOQUEO;
                    end else begin
                        estado_next_s = IDLE;
                    end
                end
                BLOQUEO: begin
                    if (espera_cnt_r == ESP_FIN) begin
                        estado_next_s = IDLE;
                    end else begin
                        estado_next_s = BLOQUEO;
                    end
                end
                default: begin
                    estado_next_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // Per-state cycle counters; each restarts from zero whenever its state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt_r  <= {MUE_W{1'b0}};
            timeout_cnt_r <= {TMO_W{1'b0}};
            espera_cnt_r  <= {ESP_W{1'b0}};
        end else begin
            if (MODsensor && (estado_r == IDLE) && (estado_next_s == IDLE)) begin
                strobe_cnt_r <= strobe_cnt_r + MUE_W'(1'b1);
            end else begin
                strobe_cnt_r <= {MUE_W{1'b0}};
            end
            if (MODsensor && (estado_r == ESPERAR) && (estado_next_s == ESPERAR)) begin
                timeout_cnt_r <= timeout_cnt_r + TMO_W'(1'b1);
            end else begin
                timeout_cnt_r <= {TMO_W{1'b0}};
            end
            if (MODsensor && (estado_r == BLOQUEO) && (estado_next_s == BLOQUEO)) begin
                espera_cnt_r <= espera_cnt_r + ESP_W'(1'b1);
            end else begin
                espera_cnt_r <= {ESP_W{1'b0}};
            end
        end
    end

    // Sample accumulation, averaged result and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r          <= 10'd0;
            num_r          <= 2'd0;
            muestra_req_r  <= 1'b0;
            regar_r        <= 1'b0;
            humedad_prom_r <= 8'd0;
            error_sensor_r <= 1'b0;
        end else begin
            muestra_req_r <= MODsensor && (estado_r == PEDIR);
            regar_r       <= riega_s;
            if (!MODsensor || timeout_s || (estado_r == EVALUAR)) begin
                acc_r <= 10'd0;
                num_r <= 2'd0;
            end else if (acepta_s) begin
                acc_r <= acc_r + {2'b00, humedad};
                num_r <= num_r + 2'd1;
            end else begin
                acc_r <= acc_r;
                num_r <= num_r;
            end
            if (timeout_s) begin
                error_sensor_r <= 1'b1;
            end else if (acepta_s) begin
                error_sensor_r <= 1'b0;
            end else begin
                error_sensor_r <= error_sensor_r;
            end
            if (MODsensor && (estado_r == EVALUAR)) begin
                humedad_prom_r <= prom_s;
            end else begin
                humedad_prom_r <= humedad_prom_r;
            end
        end
    end

endmodule

// File: tb/tb_sensor_riego.sv
// Bench for sensor_riego: table of full measurement sets, hand-written timeout /
// disconnect / reset sequences, then random sets checked against an arithmetic model.
module tb_sensor_riego;

    localparam int         M = 10;
    localparam int         T = 5;
    localparam int         E = 20;
    localparam logic [7:0] U = 8'd51;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MODsensor;
    logic [3:0] maceta;
    logic [7:0] humedad;
    logic       humedad_valid;
    logic       muestra_req;
    logic       regar;
    logic [7:0] humedad_prom;
    logic       error_sensor;

    always #5 clk = ~clk;

    sensor_riego #(
        .MUESTREO_CICLOS(M),
        .TIMEOUT_CICLOS (T),
        .ESPERA_CICLOS  (64'(E)),
        .UMBRAL         (U)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MODsensor    (MODsensor),
        .maceta       (maceta),
        .humedad      (humedad),
        .humedad_valid(humedad_valid),
        .muestra_req  (muestra_req),
        .regar        (regar),
        .humedad_prom (humedad_prom),
        .error_sensor (error_sensor)
    );

    typedef struct packed {
        logic [3:0][7:0] rd;
        logic [3:0]      mac;
        logic            stray;
        logic [7:0]      prom;
        logic            rg;
    } vec_t;

    vec_t       tbl [8];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_regar = 0;
    logic [7:0] rd [4];
    int         dl [4];
    logic       err_first;

    // Count every cycle in which regar is high.
    always @(negedge clk) begin
        if (regar === 1'b1) n_regar <= n_regar + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance until muestra_req is seen; k = cycles advanced. Optional stray valids meanwhile.
    task automatic wait_req(input int budget, input logic stray, output int k);
        k = 0;
        do begin
            humedad_valid = stray;
            if (stray) humedad = 8'd255;
            tick();
            k++;
        end while (muestra_req !== 1'b1 && k < budget);
        humedad_valid = 1'b0;
        if (muestra_req !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL req_wait: no muestra_req within %0d cycles", budget);
        end
    endtask

    // Called in a cycle where muestra_req is high; answers rd[] after dl[] cycles each.
    // Sample to_idx (0..3) is never answered; to_idx = 4 means a complete set.
    task automatic run_set(input logic [3:0] mac, input int to_idx);
        int k;
        maceta = mac;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_req(60, 1'b0, k);
            if (i == to_idx) begin
                k = 0;
                while (error_sensor !== 1'b1 && k < T + 1) begin
                    tick();
                    k++;
                end
                chk("err_rise", error_sensor, 1);
                repeat (2) tick();
                return;
            end
            repeat (dl[i]) tick();
            humedad_valid = 1'b1;
            humedad       = rd[i];
            tick();
            humedad_valid = 1'b0;
            if (i == 0) err_first = error_sensor;
        end
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         p0;
        int         sum;
        int         to_idx;
        logic [3:0] mac;
        logic [7:0] model_prom;
        logic       exp_rg;
        logic       exp_err;
        logic       stray;

        tbl[0] = '{rd: {8'd40, 8'd40, 8'd40, 8'd40}, mac: 4'd2, stray: 1'b0, prom: 8'd40, rg: 1'b1};
        tbl[1] = '{rd: {8'd51, 8'd51, 8'd52, 8'd50}, mac: 4'd2, stray: 1'b1, prom: 8'd51, rg: 1'b0};
        tbl[2] = '{rd: {8'd50, 8'd51, 8'd51, 8'd51}, mac: 4'd2, stray: 1'b1, prom: 8'd50, rg: 1'b1};
        tbl[3] = '{rd: {8'd0, 8'd0, 8'd0, 8'd0},     mac: 4'd0, stray: 1'b0, prom: 8'd0,  rg: 1'b0};
        tbl[4] = '{rd: {8'd0, 8'd0, 8'd0, 8'd0},     mac: 4'd4, stray: 1'b0, prom: 8'd0,  rg: 1'b0};
        tbl[5] = '{rd: {8'd255, 8'd255, 8'd255, 8'd255}, mac: 4'd1, stray: 1'b0, prom: 8'd255, rg: 1'b0};
        tbl[6] = '{rd: {8'd0, 8'd1, 8'd2, 8'd3},     mac: 4'd1, stray: 1'b0, prom: 8'd1,  rg: 1'b1};
        tbl[7] = '{rd: {8'd60, 8'd44, 8'd50, 8'd50}, mac: 4'd3, stray: 1'b0, prom: 8'd51, rg: 1'b0};

        rst_n         = 1'b0;
        MODsensor     = 1'b1;
        maceta        = 4'd2;
        humedad       = 8'd0;
        humedad_valid = 1'b0;
        repeat (3) tick();
        chk("rst_req", muestra_req, 0);
        chk("rst_regar", regar, 0);
        chk("rst_prom", humedad_prom, 0);
        chk("rst_err", error_sensor, 0);
        rst_n = 1'b1;
        wait_req(80, 1'b0, k);
        chk("first_req", k, M + 1);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) begin
                rd[i] = tbl[v].rd[i];
                dl[i] = 1;
            end
            p0 = n_regar;
            run_set(tbl[v].mac, 4);
            chk($sformatf("tbl%0d_prom", v), humedad_prom, tbl[v].prom);
            chk($sformatf("tbl%0d_regar", v), regar, tbl[v].rg);
            wait_req(80, tbl[v].stray, k);
            chk($sformatf("tbl%0d_gap", v), k, tbl[v].rg ? E + M + 1 : M + 1);
            chk($sformatf("tbl%0d_pulses", v), n_regar - p0, tbl[v].rg);
        end

        // Timeout after two samples: partial sum must be discarded.
        rd = '{8'd200, 8'd200, 8'd0, 8'd0};
        p0 = n_regar;
        run_set(4'd2, 2);
        chk("to_prom_hold", humedad_prom, 51);
        wait_req(80, 1'b0, k);
        chk("to_err_held", error_sensor, 1);
        rd = '{8'd10, 8'd10, 8'd10, 8'd10};
        run_set(4'd2, 4);
        chk("to_err_clear", err_first, 0);
        chk("to_prom", humedad_prom, 10);
        chk("to_regar", regar, 1);

        // Disconnect during lockout.
        repeat (5) tick();
        MODsensor = 1'b0;
        tick();
        chk("disc_req", muestra_req, 0);
        chk("disc_regar", regar, 0);
        tick();
        chk("disc_prom_hold", humedad_prom, 10);
        MODsensor = 1'b1;
        wait_req(80, 1'b0, k);
        chk("disc_reconnect_gap", k, M + 1);
        chk("disc_pulses", n_regar - p0, 1);

        rd = '{8'd100, 8'd100, 8'd100, 8'd100};
        run_set(4'd2, 4);
        chk("wet_prom", humedad_prom, 100);
        wait_req(80, 1'b0, k);

        // Reset while waiting for the second sample of a set.
        tick();
        humedad_valid = 1'b1;
        humedad       = 8'd255;
        tick();
        humedad_valid = 1'b0;
        wait_req(60, 1'b0, k);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_req", muestra_req, 0);
        chk("arst_regar", regar, 0);
        chk("arst_prom", humedad_prom, 0);
        chk("arst_err", error_sensor, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_req(80, 1'b0, k);
        chk("arst_first_req", k, M + 1);
        rd = '{8'd0, 8'd0, 8'd0, 8'd0};
        p0 = n_regar;
        run_set(4'd2, 4);
        chk("arst_set_regar", regar, 1);
        wait_req(80, 1'b0, k);
        chk("arst_set_gap", k, E + M + 1);
        chk("arst_set_pulses", n_regar - p0, 1);
        model_prom = 8'd0;

        // Random sets against an arithmetic model of the average/threshold rule.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 4; i++) begin
                rd[i] = 8'($urandom_range(0, 140));
                dl[i] = int'($urandom_range(1, 3));
            end
            mac    = 4'($urandom_range(0, 5));
            to_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 4;
            stray  = 1'($urandom_range(0, 1));
            if (to_idx < 4) begin
                exp_err = 1'b1;
                exp_rg  = 1'b0;
            end else begin
                sum        = int'(rd[0]) + int'(rd[1]) + int'(rd[2]) + int'(rd[3]);
                model_prom = 8'(sum / 4);
                exp_rg     = (model_prom < U) && (mac >= 4'd1) && (mac <= 4'd3);
                exp_err    = 1'b0;
            end
            p0 = n_regar;
            run_set(mac, to_idx);
            chk($sformatf("rnd%0d_prom", s), humedad_prom, model_prom);
            chk($sformatf("rnd%0d_err", s), error_sensor, exp_err);
            wait_req(80, stray, k);
            chk($sformatf("rnd%0d_pulses", s), n_regar - p0, exp_rg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
